// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core.
// Sequences fetch/decode/execute/mem/writeback and drives datapath strobes.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       err,
    output logic [1:0] err_code,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_ERROR  = 4'd11
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [1:0] EC_ILLEGAL = 2'b01;
    localparam logic [1:0] EC_TIMEOUT = 2'b10;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       cause;
    logic             waiting;
    logic             timeout;

    assign waiting = (state == S_FETCH) || (state == S_MEM_RD)
                  || (state == S_MEM_WR);
    assign timeout = waiting && !mem_ready
                  && (wait_cnt == CNT_W'(MEM_TIMEOUT));
    assign state_dbg = state;

    // Counter restarts on any state change, so each wait state starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RST;
            wait_cnt <= '0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (waiting && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (state_next == S_ERROR && state != S_ERROR) begin
                err      <= 1'b1;
                err_code <= cause;
            end
        end
    end

    always_comb begin
        state_next = state;
        cause      = 2'b00;
        unique case (state)
            S_RST:    state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_ERROR;
                    cause      = EC_TIMEOUT;
                end
            end
            S_DECODE: begin
                unique case (opcode)
                    OP_R:         state_next = S_EXEC_R;
                    OP_I:         state_next = S_EXEC_I;
                    OP_LD, OP_ST: state_next = S_ADDR;
                    OP_BR:        state_next = S_BRANCH;
                    default: begin
                        state_next = S_ERROR;
                        cause      = EC_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R: state_next = S_WB_ALU;
            S_EXEC_I: state_next = S_WB_ALU;
            S_ADDR: begin
                if (opcode == OP_LD) begin
                    state_next = S_MEM_RD;
                end else if (opcode == OP_ST) begin
                    state_next = S_MEM_WR;
                end else begin
                    state_next = S_ERROR;
                    cause      = EC_ILLEGAL;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_next = S_WB_MEM;
                end else if (timeout) begin
                    state_next = S_ERROR;
                    cause      = EC_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next = S_ERROR;
                    cause      = EC_TIMEOUT;
                end
            end
            S_WB_ALU: state_next = S_FETCH;
            S_WB_MEM: state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_ERROR:  state_next = S_ERROR;
            default:  state_next = S_RST;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b10;
            end
            S_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_WB_ALU: RegWrite = 1'b1;
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes expected
// per-cycle state/strobes, a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam logic [3:0] RST    = 4'd0;
    localparam logic [3:0] FETCH  = 4'd1;
    localparam logic [3:0] DECODE = 4'd2;
    localparam logic [3:0] EXEC_R = 4'd3;
    localparam logic [3:0] EXEC_I = 4'd4;
    localparam logic [3:0] ADDR   = 4'd5;
    localparam logic [3:0] MEM_RD = 4'd6;
    localparam logic [3:0] MEM_WR = 4'd7;
    localparam logic [3:0] WB_ALU = 4'd8;
    localparam logic [3:0] WB_MEM = 4'd9;
    localparam logic [3:0] BRANCH = 4'd10;
    localparam logic [3:0] ERROR  = 4'd11;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic       req;
        logic       rd;
        logic       wr;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic       pcwc;
        logic       pcsrc;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       regw;
        logic       m2r;
        logic       err;
        logic [1:0] code;
    } obs_t;

    typedef struct {
        string      tag;
        logic [3:0] st;
        obs_t       o;
    } item_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite;
    logic       PCWriteCond, PCSource, ALUSrcA, RegWrite, MemtoReg, err;
    logic [1:0] ALUSrcB, ALUOp, err_code;
    logic [3:0] state_dbg;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .mem_ready(mem_ready), .mem_req(mem_req),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .err(err),
        .err_code(err_code), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written strobe table for each state.
    function automatic obs_t want(input logic [3:0] s, input logic rdy,
                                  input logic [1:0] ec);
        obs_t o;
        o = '0;
        case (s)
            FETCH: begin
                o.req = 1; o.rd = 1; o.srcb = 2'b01;
                o.irw = rdy; o.pcw = rdy;
            end
            DECODE: o.srcb = 2'b11;
            EXEC_R: begin o.srca = 1; o.aluop = 2'b10; end
            EXEC_I: begin o.srca = 1; o.srcb = 2'b10; o.aluop = 2'b10; end
            ADDR:   begin o.srca = 1; o.srcb = 2'b10; end
            MEM_RD: begin o.req = 1; o.rd = 1; o.iord = 1; end
            MEM_WR: begin o.req = 1; o.wr = 1; o.iord = 1; end
            WB_ALU: o.regw = 1;
            WB_MEM: begin o.regw = 1; o.m2r = 1; end
            BRANCH: begin
                o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.pcsrc = 1;
            end
            default: ;
        endcase
        o.err  = (ec != 2'b00);
        o.code = ec;
        return o;
    endfunction

    task automatic go(input string tag, input logic [3:0] s,
                      input logic rdy, input logic [1:0] ec);
        item_t it;
        @(posedge clk);
        #1;
        mem_ready = rdy;
        it.tag = tag;
        it.st  = s;
        it.o   = want(s, rdy, ec);
        q.push_back(it);
    endtask

    // Drives rst_n inside the cycle; the FSM must show RST by mid-cycle.
    task automatic go_rst(input string tag, input logic r);
        item_t it;
        @(posedge clk);
        #1;
        rst_n     = r;
        mem_ready = 1'b0;
        it.tag = tag;
        it.st  = RST;
        it.o   = '0;
        q.push_back(it);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            item_t it;
            obs_t  a;
            it = q.pop_front();
            a = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite,
                 PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp,
                 RegWrite, MemtoReg, err, err_code};
            checks++;
            if (state_dbg !== it.st || a !== it.o) begin
                errors++;
                $display("FAIL %s: got state=%0d out=%b, want state=%0d out=%b",
                         it.tag, state_dbg, a, it.st, it.o);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = OP_R;
        mem_ready = 1'b0;

        go_rst("reset", 1'b0);
        go_rst("reset", 1'b0);
        go_rst("release", 1'b1);

        opcode = OP_R;
        go("r_fetch", FETCH, 1, 0);
        go("r_decode", DECODE, 1, 0);
        go("r_exec", EXEC_R, 1, 0);
        go("r_wb", WB_ALU, 1, 0);

        opcode = OP_I;
        go("i_fetch", FETCH, 1, 0);
        go("i_decode", DECODE, 1, 0);
        go("i_exec", EXEC_I, 1, 0);
        go("i_wb", WB_ALU, 1, 0);

        opcode = OP_LD;
        go("ld_fetch", FETCH, 1, 0);
        go("ld_decode", DECODE, 1, 0);
        go("ld_addr", ADDR, 1, 0);
        for (int i = 0; i < 3; i++) go("ld_wait", MEM_RD, 0, 0);
        go("ld_done", MEM_RD, 1, 0);
        go("ld_wb", WB_MEM, 1, 0);

        opcode = OP_ST;
        go("st_fetch", FETCH, 1, 0);
        go("st_decode", DECODE, 1, 0);
        go("st_addr", ADDR, 1, 0);
        go("st_mem", MEM_WR, 1, 0);

        opcode = OP_BR;
        go("br_fetch", FETCH, 1, 0);
        go("br_decode", DECODE, 1, 0);
        go("br_branch", BRANCH, 1, 0);

        opcode = OP_R;
        for (int i = 0; i < 15; i++) go("fetch_wait", FETCH, 0, 0);
        go("fetch_late", FETCH, 1, 0);
        go("late_decode", DECODE, 1, 0);
        go("late_exec", EXEC_R, 1, 0);
        go("late_wb", WB_ALU, 1, 0);

        opcode = OP_ST;
        go("st2_fetch", FETCH, 1, 0);
        go("st2_decode", DECODE, 1, 0);
        go("st2_addr", ADDR, 1, 0);
        go("st2_wait", MEM_WR, 0, 0);
        go_rst("st2_abort", 1'b0);
        go_rst("st2_release", 1'b1);

        for (int i = 0; i < 16; i++) go("to_wait", FETCH, 0, 0);
        for (int i = 0; i < 3; i++) go("to_error", ERROR, i[0], 2'b10);
        go_rst("to_reset", 1'b0);
        go_rst("to_release", 1'b1);

        opcode = OP_BAD;
        go("bad_fetch", FETCH, 1, 0);
        go("bad_decode", DECODE, 1, 0);
        for (int i = 0; i < 20; i++) go("bad_error", ERROR, i[0], 2'b01);
        go_rst("bad_reset", 1'b0);
        go_rst("bad_release", 1'b1);
        opcode = OP_R;
        go("post_fetch", FETCH, 1, 0);
        go("post_decode", DECODE, 1, 0);

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
